request_arbiter: RTL and testbench

//  - Round-robin N:1 arbiter sitting directly upstream of the request pipeline.
//  - Merges NUM_REQ requester channels (address/id/valid, stall backpressure) into one registered stream.
//  - The merged stream drives the pipeline input (in_address/in_id/in_valid, out_stall).
//  - Tags each beat with its source index so the downstream side can route responses.

---
 rtl/request_arbiter_pkg.sv | 42 ++++
 rtl/request_arbiter_picker.sv | 57 +++++
 rtl/request_arbiter.sv | 114 +++++++++++
 tb/tb_request_arbiter.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/request_arbiter_pkg.sv
// ============================================================================
// Module  : request_arbiter_pkg
// Brief   : Shared widths, defaults and helpers for the request arbiter.
//           Also carries the build-wide defines (ADDRESS_WIDTH, ID_WIDTH,
//           ARB_NUM_REQ), each overridable on the command line. The optional
//           switch ARB_GRANT_COUNT_EN enables per-requester grant counters.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef ADDRESS_WIDTH
`define ADDRESS_WIDTH 32
`endif

`ifndef ID_WIDTH
`define ID_WIDTH 4
`endif

`ifndef ARB_NUM_REQ
`define ARB_NUM_REQ 4
`endif

// ARB_GRANT_COUNT_EN is left undefined by default (counters disabled).

package request_arbiter_pkg;

  localparam int ARB_NUM_REQ_DEF = `ARB_NUM_REQ;
  localparam int ADDR_W_DEF      = `ADDRESS_WIDTH;
  localparam int ID_W_DEF        = `ID_WIDTH;

`ifdef ARB_GRANT_COUNT_EN
  localparam int GNT_CNT_WIDTH_DEF = 16;
`endif

  // Next round-robin slot after idx, wrapping n-1 -> 0.
  function automatic int rr_wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/request_arbiter_picker.sv
// ============================================================================
// Module  : rr_picker
// Brief   : Combinational round-robin selector. Scans valid starting at
//           rr_ptr (wrapping) and returns the first valid index as a one-hot
//           grant plus its encoded index.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_picker
  import request_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = ARB_NUM_REQ_DEF,
  parameter int SRC_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]   valid,
  input  logic [SRC_WIDTH-1:0] rr_ptr,
  output logic [NUM_REQ-1:0]   grant,
  output logic                 any_valid,
  output logic [SRC_WIDTH-1:0] winner
);

  // Rotate so rr_ptr lands at bit 0; the lowest set bit is then the winner.
  logic [2*NUM_REQ-1:0] dbl_valid;
  logic [2*NUM_REQ-1:0] rot_shift;
  logic [NUM_REQ-1:0]   rot_valid;
  logic [NUM_REQ-1:0]   rot_onehot;
  logic [2*NUM_REQ-1:0] dbl_onehot;
  logic [2*NUM_REQ-1:0] back_shift;

  // Per output bit, the set of requester indices that have that bit set.
  logic [SRC_WIDTH-1:0][NUM_REQ-1:0] enc_mask;

  assign any_valid  = |valid;
  assign dbl_valid  = {valid, valid};
  assign rot_shift  = dbl_valid >> rr_ptr;
  assign rot_valid  = rot_shift[NUM_REQ-1:0];

  // Isolate the lowest set bit (two's-complement trick).
  assign rot_onehot = rot_valid & (~rot_valid + NUM_REQ'(1));

  // Rotate the one-hot back into requester numbering.
  assign dbl_onehot = {rot_onehot, rot_onehot};
  assign back_shift = dbl_onehot << rr_ptr;
  assign grant      = back_shift[2*NUM_REQ-1:NUM_REQ];

  // One-hot to binary: each winner bit is the OR of grants whose index has it.
  for (genvar b = 0; b < SRC_WIDTH; b++) begin : g_bit
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_idx
      assign enc_mask[b][i] = 1'((i >> b) & 1);
    end
    assign winner[b] = |(grant & enc_mask[b]);
  end

endmodule

`default_nettype wire

// File: rtl/request_arbiter.sv
// ============================================================================
// Module  : request_arbiter
// Brief   : Round-robin NUM_REQ:1 arbiter feeding the request pipeline.
//           Merges requester channels into one registered stream, tagging
//           each beat with its source index. Backpressure on both sides uses
//           valid/stall: a beat moves when valid=1 and stall=0.
//           Optional feature: define ARB_GRANT_COUNT_EN for saturating
//           per-requester grant counters on the grant_count port.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module request_arbiter
  import request_arbiter_pkg::*;
#(
  parameter int NUM_REQ       = ARB_NUM_REQ_DEF,
  parameter int ADDRESS_WIDTH = ADDR_W_DEF,
  parameter int ID_WIDTH      = ID_W_DEF
`ifdef ARB_GRANT_COUNT_EN
  ,
  parameter int GNT_CNT_WIDTH = GNT_CNT_WIDTH_DEF
`endif
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]  req_address,
  input  logic [NUM_REQ-1:0][ID_WIDTH-1:0]       req_id,
  input  logic [NUM_REQ-1:0]                     req_valid,
  output logic [NUM_REQ-1:0]                     req_stall,
  output logic [ADDRESS_WIDTH-1:0]               out_address,
  output logic [ID_WIDTH-1:0]                    out_id,
  output logic [$clog2(NUM_REQ)-1:0]             out_src,
  output logic                                   out_valid,
  input  logic                                   in_stall
`ifdef ARB_GRANT_COUNT_EN
  ,
  output logic [NUM_REQ-1:0][GNT_CNT_WIDTH-1:0]  grant_count
`endif
);

  localparam int SRC_WIDTH = $clog2(NUM_REQ);

  logic [SRC_WIDTH-1:0] rr_ptr;
  logic [NUM_REQ-1:0]   grant;
  logic                 any_valid;
  logic [SRC_WIDTH-1:0] winner;
  logic                 load_en;

  rr_picker #(
    .NUM_REQ   (NUM_REQ),
    .SRC_WIDTH (SRC_WIDTH)
  ) u_picker (
    .valid     (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .any_valid (any_valid),
    .winner    (winner)
  );

  // The output register can take a new beat when empty or when drained.
  assign load_en = !out_valid || !in_stall;

  // Only the winner sees stall=0, and only when the register is loading.
  // Reset forces every stall high so no requester believes it was taken.
  assign req_stall = reset ? {NUM_REQ{1'b1}} : ~(grant & {NUM_REQ{load_en}});

  // Output register: load the winner (or go idle) whenever load_en is high.
  // Payload is left untouched on idle loads so it only changes with a beat.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_address <= '0;
      out_id      <= '0;
      out_src     <= '0;
    end else if (load_en) begin
      out_valid <= any_valid;
      if (any_valid) begin
        out_address <= req_address[winner];
        out_id      <= req_id[winner];
        out_src     <= winner;
      end
    end
  end

  // Round-robin pointer moves past the winner only when its beat is taken,
  // so a stalled winner keeps priority.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr <= '0;
    end else if (load_en && any_valid) begin
      rr_ptr <= SRC_WIDTH'(rr_wrap_inc(int'(winner), NUM_REQ));
    end
  end

`ifdef ARB_GRANT_COUNT_EN
  for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
    logic [GNT_CNT_WIDTH-1:0] cnt;

    // Saturating count of accepted grants for requester i.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt <= '0;
      end else if (load_en && grant[i] && (cnt != {GNT_CNT_WIDTH{1'b1}})) begin
        cnt <= cnt + GNT_CNT_WIDTH'(1);
      end
    end

    assign grant_count[i] = cnt;
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_request_arbiter.sv
// ============================================================================
// Module  : tb_request_arbiter
// Brief   : Self-checking bench for request_arbiter: directed scenarios with
//           literal expectations, then randomized traffic compared each cycle
//           against a behavioural round-robin model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_request_arbiter;
  import request_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int AW = `ADDRESS_WIDTH;
  localparam int IW = `ID_WIDTH;
  localparam int SW = $clog2(N);
`ifdef ARB_GRANT_COUNT_EN
  localparam int CW = 2;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic [N-1:0][AW-1:0]  req_address;
  logic [N-1:0][IW-1:0]  req_id;
  logic [N-1:0]          req_valid;
  logic [N-1:0]          req_stall;
  logic [AW-1:0]         out_address;
  logic [IW-1:0]         out_id;
  logic [SW-1:0]         out_src;
  logic                  out_valid;
  logic                  in_stall;
`ifdef ARB_GRANT_COUNT_EN
  logic [N-1:0][CW-1:0]  grant_count;
`endif

  int checks = 0;
  int passed = 0;

  request_arbiter #(
    .NUM_REQ       (N),
    .ADDRESS_WIDTH (AW),
    .ID_WIDTH      (IW)
`ifdef ARB_GRANT_COUNT_EN
    ,
    .GNT_CNT_WIDTH (CW)
`endif
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req_address (req_address),
    .req_id      (req_id),
    .req_valid   (req_valid),
    .req_stall   (req_stall),
    .out_address (out_address),
    .out_id      (out_id),
    .out_src     (out_src),
    .out_valid   (out_valid),
    .in_stall    (in_stall)
`ifdef ARB_GRANT_COUNT_EN
    ,
    .grant_count (grant_count)
`endif
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  bit            m_valid = 1'b0;
  logic [AW-1:0] m_addr  = '0;
  logic [IW-1:0] m_id    = '0;
  int            m_src   = 0;
  int            m_ptr   = 0;
  logic [N-1:0]  m_acc   = '0;   // requesters whose beat was taken at the last edge
`ifdef ARB_GRANT_COUNT_EN
  int            m_cnt [N];
  initial for (int i = 0; i < N; i++) m_cnt[i] = 0;
`endif

  // First valid requester scanning from ptr with wrap; -1 if none.
  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Model state advance on each rising edge.
  always @(posedge clk) begin
    int w;
    bit load;
    if (reset) begin
      m_valid <= 1'b0;
      m_addr  <= '0;
      m_id    <= '0;
      m_src   <= 0;
      m_ptr   <= 0;
      m_acc   <= '0;
`ifdef ARB_GRANT_COUNT_EN
      for (int i = 0; i < N; i++) m_cnt[i] <= 0;
`endif
    end else begin
      load = !m_valid || !in_stall;
      w    = pick(req_valid, m_ptr);
      m_acc <= '0;
      if (load) begin
        m_valid <= (w >= 0);
        if (w >= 0) begin
          m_addr   <= req_address[w];
          m_id     <= req_id[w];
          m_src    <= w;
          m_ptr    <= (w + 1) % N;
          m_acc[w] <= 1'b1;
`ifdef ARB_GRANT_COUNT_EN
          if (m_cnt[w] < (1 << CW) - 1) m_cnt[w] <= m_cnt[w] + 1;
`endif
        end
      end
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    logic [N-1:0] es;
    int w;
    es = '1;
    if (!reset) begin
      w = pick(req_valid, m_ptr);
      if ((!m_valid || !in_stall) && w >= 0) es[w] = 1'b0;
    end
    chk("model_req_stall", 64'(req_stall), 64'(es));
    chk("model_out_valid", 64'(out_valid), 64'(m_valid));
    if (m_valid) begin
      chk("model_out_address", 64'(out_address), 64'(m_addr));
      chk("model_out_id",      64'(out_id),      64'(m_id));
      chk("model_out_src",     64'(out_src),     64'(m_src));
    end
`ifdef ARB_GRANT_COUNT_EN
    for (int i = 0; i < N; i++) chk("model_grant_count", 64'(grant_count[i]), 64'(m_cnt[i]));
`endif
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- stimulus and directed checks ----------------
  initial begin
    reset       = 1'b1;
    req_valid   = '0;
    req_address = '0;
    req_id      = '0;
    in_stall    = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_req_stall", 64'(req_stall), 64'hF);
    chk("rst_out_valid", 64'(out_valid), 64'h0);
    chk("rst_out_src",   64'(out_src),   64'h0);
    chk("rst_out_addr",  64'(out_address), 64'h0);
    reset = 1'b0;
    tick();

    // Single requester 2
    req_valid      = 4'b0100;
    req_address[2] = AW'(32'h10);
    req_id[2]      = IW'(3);
    #1;
    chk("single_req_stall", 64'(req_stall), 64'hB);
    tick();
    chk("single_out_valid", 64'(out_valid),   64'h1);
    chk("single_out_src",   64'(out_src),     64'h2);
    chk("single_out_addr",  64'(out_address), 64'h10);
    chk("single_out_id",    64'(out_id),      64'h3);

    // Reset mid-stream while out_valid=1
    req_valid = 4'b1111;
    for (int i = 0; i < N; i++) begin
      req_address[i] = AW'(32'h100 * (i + 1));
      req_id[i]      = IW'(i);
    end
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'h0);
    chk("midrst_req_stall", 64'(req_stall), 64'hF);
    tick();
    reset = 1'b0;

    // Fairness: all valid, no stall -> strict rotation from 0
    for (int c = 0; c < 8; c++) begin
      tick();
      chk("fair_out_src",  64'(out_src),     64'(c % 4));
      chk("fair_out_addr", 64'(out_address), 64'(32'h100 * ((c % 4) + 1)));
    end

    // Backpressure: hold for 3 cycles, then release
    in_stall = 1'b1;
    #1;
    chk("bp_req_stall", 64'(req_stall), 64'hF);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_out_src",    64'(out_src),   64'h3);
      chk("bp_out_valid",  64'(out_valid), 64'h1);
      chk("bp_req_stall",  64'(req_stall), 64'hF);
    end
    in_stall = 1'b0;
    #1;
    chk("bp_release_stall", 64'(req_stall), 64'hE);
    tick();
    chk("bp_next_src",      64'(out_src),   64'h0);
    chk("bp_next_stall",    64'(req_stall), 64'hD);

    // Skip/wrap: get rr_ptr to 3, then only 0 and 1 valid
    req_valid = 4'b0100;
    tick();
    chk("wrap_setup_src", 64'(out_src), 64'h2);
    req_valid = 4'b0011;
    tick();
    chk("wrap_src_a", 64'(out_src), 64'h0);
    tick();
    chk("wrap_src_b", 64'(out_src), 64'h1);
    tick();
    chk("wrap_src_c", 64'(out_src), 64'h0);

    // No requester valid -> out_valid drops
    req_valid = '0;
    tick();
    chk("idle_out_valid", 64'(out_valid), 64'h0);

`ifdef ARB_GRANT_COUNT_EN
    // Saturation: 5 grants to requester 1 with a 2-bit counter
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req_valid = 4'b0010;
    for (int c = 0; c < 5; c++) tick();
    req_valid = '0;
    chk("cnt_sat_1", 64'(grant_count[1]), 64'h3);
    chk("cnt_0",     64'(grant_count[0]), 64'h0);
    chk("cnt_2",     64'(grant_count[2]), 64'h0);
    chk("cnt_3",     64'(grant_count[3]), 64'h0);
`endif

    // Randomized traffic: requesters hold a beat until the model accepts it
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 199) == 0) reset = 1'b1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] || m_acc[i]) begin
          if ($urandom_range(0, 9) < 6) begin
            req_valid[i]   = 1'b1;
            req_address[i] = AW'($urandom);
            req_id[i]      = IW'($urandom);
          end else begin
            req_valid[i] = 1'b0;
          end
        end
      end
      in_stall = ($urandom_range(0, 9) < 3);
    end

    tick();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
